// File: rtl/ldpc_wb_host_pkg.sv
// Shared encodings for the LDPC Wishbone host sequencer.
// Contents: command opcodes, response status codes and the FSM state type.
// Used by ldpc_wb_host_seq and visible to any command source that builds requests.
package ldpc_wb_host_pkg;

    // Command opcodes carried on cmd_op
    localparam logic [1:0] OP_WR   = 2'b00;
    localparam logic [1:0] OP_RD   = 2'b01;
    localparam logic [1:0] OP_POLL = 2'b10;
    localparam logic [1:0] OP_ILL  = 2'b11;

    // Response status codes carried on rsp_status
    localparam logic [1:0] ST_OK   = 2'b00;
    localparam logic [1:0] ST_TMO  = 2'b01;
    localparam logic [1:0] ST_EXH  = 2'b10;
    localparam logic [1:0] ST_ILL  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_GAP  = 2'd2,
        S_RESP = 2'd3
    } state_t;

endpackage

// File: rtl/ldpc_wb_host_seq.sv
// Purpose: Wishbone classic initiator executing write/read/poll commands against the LDPC core slave.
// Latency: cyc/stb rise the cycle after command accept; rsp_valid rises the cycle after ack or timeout.
// Backpressure: cmd_ready is low from accept until the cycle after the rsp_valid/rsp_ready handshake.
//
// Ports:
//   wb_clk_i, wb_rst_i         clock, synchronous active-high reset
//   cmd_*  (valid/ready)       command: op, address, data/expected, select, poll mask, max polls
//   rsp_*  (valid/ready)       response: read data, status, number of reads performed
//   wbm_*                      Wishbone classic master port towards the LDPC core
//   busy                       high whenever the sequencer is not idle
module ldpc_wb_host_seq
    import ldpc_wb_host_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int TIMEOUT  = 255,
    parameter int POLL_GAP = 16,   // must be at least 1
    parameter int CNT_W    = 16
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [ADDR_W-1:0]     cmd_adr,
    input  logic [DATA_W-1:0]     cmd_dat,
    input  logic [DATA_W/8-1:0]   cmd_sel,
    input  logic [DATA_W-1:0]     cmd_mask,
    input  logic [CNT_W-1:0]      cmd_max_polls,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_dat,
    output logic [1:0]            rsp_status,
    output logic [CNT_W-1:0]      rsp_polls,

    output logic                  wbm_cyc_o,
    output logic                  wbm_stb_o,
    output logic                  wbm_we_o,
    output logic [DATA_W/8-1:0]   wbm_sel_o,
    output logic [ADDR_W-1:0]     wbm_adr_o,
    output logic [DATA_W-1:0]     wbm_dat_o,
    input  logic                  wbm_ack_i,
    input  logic [DATA_W-1:0]     wbm_dat_i,

    output logic                  busy
);

    // Wait counter must hold TIMEOUT itself; gap counter runs 0..POLL_GAP-1.
    localparam int TMO_W = $clog2(TIMEOUT + 2);
    localparam int GAP_W = $clog2(POLL_GAP + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_GAP - 1);

    state_t              r_state;
    logic [1:0]          r_op;
    logic [DATA_W-1:0]   r_exp;
    logic [DATA_W-1:0]   r_mask;
    logic [CNT_W-1:0]    r_max;
    logic [CNT_W-1:0]    r_polls;
    logic [TMO_W-1:0]    r_wait;
    logic [GAP_W-1:0]    r_gap;

    logic                w_accept;
    logic                w_rsp_done;
    logic                w_match;
    logic                w_polls_last;
    logic [CNT_W-1:0]    w_polls_inc;

    assign w_accept     = cmd_valid && cmd_ready;
    assign w_rsp_done   = rsp_valid && rsp_ready;
    // Read counter saturates rather than wrapping so a huge poll budget never reports a small count.
    assign w_polls_inc  = (&r_polls) ? r_polls : r_polls + CNT_W'(1);
    assign w_match      = ((wbm_dat_i ^ r_exp) & r_mask) == '0;
    assign w_polls_last = (w_polls_inc == r_max);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state    <= S_IDLE;
            r_op       <= OP_WR;
            r_exp      <= '0;
            r_mask     <= '0;
            r_max      <= '0;
            r_polls    <= '0;
            r_wait     <= '0;
            r_gap      <= '0;
            cmd_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_dat    <= '0;
            rsp_status <= ST_OK;
            rsp_polls  <= '0;
            wbm_cyc_o  <= 1'b0;
            wbm_stb_o  <= 1'b0;
            wbm_we_o   <= 1'b0;
            wbm_sel_o  <= '0;
            wbm_adr_o  <= '0;
            wbm_dat_o  <= '0;
            busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op      <= cmd_op;
                        r_exp     <= cmd_dat;
                        r_mask    <= cmd_mask;
                        r_max     <= (cmd_max_polls == '0) ? CNT_W'(1) : cmd_max_polls;
                        r_polls   <= '0;
                        r_wait    <= '0;
                        r_gap     <= '0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (cmd_op == OP_ILL) begin
                            // Illegal op never touches the bus.
                            r_state    <= S_RESP;
                            rsp_valid  <= 1'b1;
                            rsp_status <= ST_ILL;
                            rsp_dat    <= '0;
                            rsp_polls  <= '0;
                        end else begin
                            r_state   <= S_BUS;
                            wbm_cyc_o <= 1'b1;
                            wbm_stb_o <= 1'b1;
                            wbm_we_o  <= (cmd_op == OP_WR);
                            wbm_sel_o <= cmd_sel;
                            wbm_adr_o <= cmd_adr;
                            wbm_dat_o <= (cmd_op == OP_WR) ? cmd_dat : '0;
                        end
                    end
                end

                S_BUS: begin
                    // Ack is checked before the timeout so a last-cycle ack still completes normally.
                    if (wbm_ack_i) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        r_wait    <= '0;
                        if (r_op == OP_WR) begin
                            r_state    <= S_RESP;
                            rsp_valid  <= 1'b1;
                            rsp_status <= ST_OK;
                            rsp_dat    <= '0;
                            rsp_polls  <= '0;
                        end else begin
                            r_polls <= w_polls_inc;
                            if (r_op == OP_RD || w_match) begin
                                r_state    <= S_RESP;
                                rsp_valid  <= 1'b1;
                                rsp_status <= ST_OK;
                                rsp_dat    <= wbm_dat_i;
                                rsp_polls  <= w_polls_inc;
                            end else if (w_polls_last) begin
                                r_state    <= S_RESP;
                                rsp_valid  <= 1'b1;
                                rsp_status <= ST_EXH;
                                rsp_dat    <= wbm_dat_i;
                                rsp_polls  <= w_polls_inc;
                            end else begin
                                r_state <= S_GAP;
                                r_gap   <= '0;
                            end
                        end
                    end else if (r_wait == TMO_LAST) begin
                        // Wait counter starts at 0 on the first stb cycle, so stb was high TIMEOUT+1 cycles.
                        wbm_cyc_o  <= 1'b0;
                        wbm_stb_o  <= 1'b0;
                        r_wait     <= '0;
                        r_state    <= S_RESP;
                        rsp_valid  <= 1'b1;
                        rsp_status <= ST_TMO;
                        rsp_dat    <= '0;
                        rsp_polls  <= (r_op == OP_WR) ? '0 : r_polls;
                    end else begin
                        r_wait <= r_wait + TMO_W'(1);
                    end
                end

                S_GAP: begin
                    // Gap entry cycle counts as idle cycle 0; stb returns after POLL_GAP idle cycles.
                    if (r_gap == GAP_LAST) begin
                        r_state   <= S_BUS;
                        r_wait    <= '0;
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                    end else begin
                        r_gap <= r_gap + GAP_W'(1);
                    end
                end

                S_RESP: begin
                    if (w_rsp_done) begin
                        r_state   <= S_IDLE;
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ldpc_wb_host_seq.sv
// Bench for ldpc_wb_host_seq: scenario tasks plus a randomized back-to-back run,
// all checked against a command-level reference model and a behavioural Wishbone slave.
module tb_ldpc_wb_host_seq;

    logic        wb_clk_i;
    logic        wb_rst_i;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic [3:0]  cmd_sel;
    logic [31:0] cmd_mask;
    logic [15:0] cmd_max_polls;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dat;
    logic [1:0]  rsp_status;
    logic [15:0] rsp_polls;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic        wbm_ack_i;
    logic [31:0] wbm_dat_i;
    logic        busy;

    ldpc_wb_host_seq dut (
        .wb_clk_i      (wb_clk_i),
        .wb_rst_i      (wb_rst_i),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_adr       (cmd_adr),
        .cmd_dat       (cmd_dat),
        .cmd_sel       (cmd_sel),
        .cmd_mask      (cmd_mask),
        .cmd_max_polls (cmd_max_polls),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_dat       (rsp_dat),
        .rsp_status    (rsp_status),
        .rsp_polls     (rsp_polls),
        .wbm_cyc_o     (wbm_cyc_o),
        .wbm_stb_o     (wbm_stb_o),
        .wbm_we_o      (wbm_we_o),
        .wbm_sel_o     (wbm_sel_o),
        .wbm_adr_o     (wbm_adr_o),
        .wbm_dat_o     (wbm_dat_o),
        .wbm_ack_i     (wbm_ack_i),
        .wbm_dat_i     (wbm_dat_i),
        .busy          (busy)
    );

    initial begin
        wb_clk_i = 1'b0;
        forever #5 wb_clk_i = ~wb_clk_i;
    end

    int n_checks = 0;
    int n_errors = 0;
    int cyc_n = 0;

    always @(posedge wb_clk_i) cyc_n <= cyc_n + 1;

    // Slave configuration
    int          ack_lat   = 0;
    bit          never_ack = 0;
    bit          stray     = 0;
    logic [31:0] rd_q[$];

    // Slave log
    int          n_trans, n_wr, stb_run, stb_len, first_start, last_ack_cyc;
    int          last_end = -1000;
    int          gaps[$];
    logic [31:0] wr_adr, wr_dat;
    logic [3:0]  wr_sel;

    // Behavioural Wishbone slave: acks the (ack_lat+1)-th stb cycle, read data from rd_q.
    initial begin
        wbm_ack_i = 1'b0;
        wbm_dat_i = '0;
        stb_run   = 0;
        forever begin
            @(posedge wb_clk_i); #1;
            wbm_ack_i = 1'b0;
            wbm_dat_i = '0;
            if (wbm_cyc_o && wbm_stb_o) begin
                if (stb_run == 0) begin
                    n_trans++;
                    if (n_trans == 1) first_start = cyc_n;
                    gaps.push_back(cyc_n - last_end - 1);
                end
                stb_run++;
                stb_len  = stb_run;
                last_end = cyc_n;
                if (!never_ack && stb_run == ack_lat + 1) begin
                    wbm_ack_i    = 1'b1;
                    last_ack_cyc = cyc_n;
                    if (wbm_we_o) begin
                        n_wr++;
                        wr_adr = wbm_adr_o;
                        wr_dat = wbm_dat_o;
                        wr_sel = wbm_sel_o;
                    end else begin
                        wbm_dat_i = (rd_q.size() > 0) ? rd_q.pop_front() : 32'h0;
                    end
                end
            end else begin
                stb_run = 0;
                if (stray && $urandom_range(0, 3) == 0) begin
                    wbm_ack_i = 1'b1;
                    wbm_dat_i = $urandom;
                end
            end
        end
    end

    // Observations from the last command
    logic [1:0]  o_st;
    logic [31:0] o_dat;
    logic [15:0] o_polls;
    bit          o_hung, o_stable, o_cr_resp, o_busy_resp;
    logic [2:0]  o_after;
    int          acc_cyc, rsp_cyc;

    // Model expectations
    logic [1:0]  e_st;
    logic [31:0] e_dat;
    logic [15:0] e_polls;
    int          e_ntr;

    // Command-level model: outcome depends only on op, slave data sequence and ack behaviour.
    task automatic model(input logic [1:0] op, input logic [31:0] exp, input logic [31:0] mask,
                         input logic [15:0] maxp, input bit tmo);
        logic [31:0] q[$];
        logic [31:0] dv;
        int m;
        q = rd_q;
        e_dat = '0; e_polls = '0; e_ntr = 1; e_st = 2'b00;
        if (op == 2'b11) begin
            e_st = 2'b11; e_ntr = 0;
        end else if (tmo) begin
            e_st = 2'b01;
        end else if (op == 2'b01) begin
            e_dat = (q.size() > 0) ? q[0] : 32'h0;
            e_polls = 16'd1;
        end else if (op == 2'b10) begin
            m = (maxp == 16'd0) ? 1 : int'(maxp);
            e_st = 2'b10;
            for (int i = 1; i <= m; i++) begin
                dv = (q.size() > 0) ? q.pop_front() : 32'h0;
                e_dat = dv; e_polls = 16'(i); e_ntr = i;
                if ((dv & mask) == (exp & mask)) begin
                    e_st = 2'b00;
                    break;
                end
            end
        end
    endtask

    // Drives one command through accept, response, optional hold, and handshake.
    task automatic run_cmd(input logic [1:0] op, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic [31:0] mask, input logic [15:0] maxp,
                           input int hold);
        int n;
        gaps.delete();
        n_trans = 0; n_wr = 0; stb_len = 0; first_start = -1; last_ack_cyc = -1;
        o_hung = 0; o_stable = 1;
        @(posedge wb_clk_i); #1;
        cmd_valid = 1'b1; cmd_op = op; cmd_adr = adr; cmd_dat = dat;
        cmd_sel = sel; cmd_mask = mask; cmd_max_polls = maxp;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(posedge wb_clk_i); #1; n++;
        end
        @(posedge wb_clk_i); #1;
        acc_cyc = cyc_n;
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom); cmd_adr = $urandom; cmd_dat = $urandom;
        cmd_mask = $urandom; cmd_max_polls = 16'($urandom);
        n = 0;
        while (!rsp_valid && n < 2000) begin
            @(posedge wb_clk_i); #1; n++;
        end
        if (!rsp_valid) o_hung = 1;
        rsp_cyc = cyc_n;
        o_st = rsp_status; o_dat = rsp_dat; o_polls = rsp_polls;
        o_cr_resp = cmd_ready; o_busy_resp = busy;
        for (int i = 0; i < hold; i++) begin
            @(posedge wb_clk_i); #1;
            if (!rsp_valid || rsp_status !== o_st || rsp_dat !== o_dat ||
                rsp_polls !== o_polls || cmd_ready) o_stable = 0;
        end
        rsp_ready = 1'b1;
        @(posedge wb_clk_i); #1;
        rsp_ready = 1'b0;
        o_after = {rsp_valid, cmd_ready, busy};
    endtask

    task automatic test_reset();
        wb_rst_i = 1'b1;
        cmd_valid = 0; cmd_op = 0; cmd_adr = 0; cmd_dat = 0; cmd_sel = 0;
        cmd_mask = 0; cmd_max_polls = 0; rsp_ready = 0;
        repeat (3) @(posedge wb_clk_i);
        #1;
        n_checks++;
        if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o, rsp_valid,
             rsp_dat, rsp_status, rsp_polls, busy} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: cyc=%b stb=%b we=%b rsp_valid=%b busy=%b status=%b want all 0",
                     wbm_cyc_o, wbm_stb_o, wbm_we_o, rsp_valid, busy, rsp_status);
        end
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_errors++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready);
        end
        wb_rst_i = 1'b0;
    endtask

    task automatic test_write();
        ack_lat = 2;
        model(2'b00, 32'hA5A5_0001, 32'h0, 16'd0, 1'b0);
        run_cmd(2'b00, 32'h3000_0004, 32'hA5A5_0001, 4'hF, 32'h0, 16'd0, 0);
        n_checks++;
        if ({o_st, o_dat, o_polls} !== {e_st, e_dat, e_polls}) begin
            n_errors++; $display("FAIL write_rsp: got %h/%h/%0d want %h/%h/%0d", o_st, o_dat, o_polls, e_st, e_dat, e_polls);
        end
        n_checks++;
        if (n_wr !== 1 || wr_adr !== 32'h3000_0004 || wr_dat !== 32'hA5A5_0001 || wr_sel !== 4'hF) begin
            n_errors++; $display("FAIL write_bus: writes=%0d adr=%h dat=%h sel=%h want 1/30000004/a5a50001/f", n_wr, wr_adr, wr_dat, wr_sel);
        end
        n_checks++;
        if (stb_len !== 3 || first_start !== acc_cyc || rsp_cyc !== last_ack_cyc + 1) begin
            n_errors++; $display("FAIL write_timing: stb_len=%0d start=%0d acc=%0d rsp=%0d ack=%0d", stb_len, first_start, acc_cyc, rsp_cyc, last_ack_cyc);
        end
        n_checks++;
        if (o_after !== 3'b010) begin
            n_errors++; $display("FAIL write_after_hs: {rsp_valid,cmd_ready,busy}=%b want 010", o_after);
        end
    endtask

    task automatic test_read();
        ack_lat = 1;
        rd_q.delete(); rd_q.push_back(32'h1234_5678);
        model(2'b01, 32'h0, 32'h0, 16'd0, 1'b0);
        run_cmd(2'b01, 32'h3000_0010, 32'h0, 4'hF, 32'h0, 16'd0, 0);
        n_checks++;
        if ({o_st, o_dat, o_polls} !== {e_st, e_dat, e_polls} || o_dat !== 32'h1234_5678) begin
            n_errors++; $display("FAIL read_rsp: got %h/%h/%0d want %h/%h/%0d", o_st, o_dat, o_polls, e_st, e_dat, e_polls);
        end
        n_checks++;
        if (n_trans !== 1 || n_wr !== 0) begin
            n_errors++; $display("FAIL read_bus: trans=%0d writes=%0d want 1/0", n_trans, n_wr);
        end
    endtask

    task automatic test_poll_match();
        ack_lat = 0;
        rd_q.delete(); rd_q.push_back(32'h0); rd_q.push_back(32'h0); rd_q.push_back(32'h1);
        model(2'b10, 32'h1, 32'h1, 16'd10, 1'b0);
        run_cmd(2'b10, 32'h3000_0020, 32'h1, 4'hF, 32'h1, 16'd10, 0);
        n_checks++;
        if ({o_st, o_dat, o_polls} !== {e_st, e_dat, e_polls} || o_polls !== 16'd3) begin
            n_errors++; $display("FAIL poll_match_rsp: got %h/%h/%0d want %h/%h/%0d", o_st, o_dat, o_polls, e_st, e_dat, e_polls);
        end
        n_checks++;
        if (n_trans !== 3) begin
            n_errors++; $display("FAIL poll_match_trans: got %0d want 3", n_trans);
        end
        for (int i = 1; i < gaps.size(); i++) begin
            n_checks++;
            if (gaps[i] !== 16) begin
                n_errors++; $display("FAIL poll_gap_%0d: got %0d idle cycles want 16", i, gaps[i]);
            end
        end
    endtask

    task automatic test_poll_exhaust();
        ack_lat = 1;
        rd_q.delete();
        model(2'b10, 32'h1, 32'h1, 16'd4, 1'b0);
        run_cmd(2'b10, 32'h3000_0020, 32'h1, 4'hF, 32'h1, 16'd4, 0);
        n_checks++;
        if ({o_st, o_polls, n_trans} !== {e_st, e_polls, e_ntr} || o_st !== 2'b10 || o_polls !== 16'd4) begin
            n_errors++; $display("FAIL poll_exh4: got %h/%0d/%0d want %h/%0d/%0d", o_st, o_polls, n_trans, e_st, e_polls, e_ntr);
        end
        model(2'b10, 32'h1, 32'h1, 16'd0, 1'b0);
        run_cmd(2'b10, 32'h3000_0020, 32'h1, 4'hF, 32'h1, 16'd0, 0);
        n_checks++;
        if ({o_st, o_polls, n_trans} !== {e_st, e_polls, e_ntr} || n_trans !== 1) begin
            n_errors++; $display("FAIL poll_exh0: got %h/%0d/%0d want %h/%0d/%0d", o_st, o_polls, n_trans, e_st, e_polls, e_ntr);
        end
    endtask

    task automatic test_timeout_illegal();
        never_ack = 1;
        model(2'b01, 32'h0, 32'h0, 16'd0, 1'b1);
        run_cmd(2'b01, 32'h3000_0030, 32'h0, 4'hF, 32'h0, 16'd0, 0);
        never_ack = 0;
        n_checks++;
        if ({o_st, o_dat, o_polls} !== {e_st, e_dat, e_polls} || o_hung) begin
            n_errors++; $display("FAIL timeout_rsp: got %h/%h/%0d hung=%0d want %h/%h/%0d", o_st, o_dat, o_polls, o_hung, e_st, e_dat, e_polls);
        end
        n_checks++;
        if (stb_len !== 256 || rsp_cyc !== last_end + 1) begin
            n_errors++; $display("FAIL timeout_len: stb cycles=%0d want 256, rsp=%0d last_stb=%0d", stb_len, rsp_cyc, last_end);
        end
        // Ack landing on the final allowed cycle completes normally.
        ack_lat = 255;
        rd_q.delete(); rd_q.push_back(32'hCAFE_0255);
        model(2'b01, 32'h0, 32'h0, 16'd0, 1'b0);
        run_cmd(2'b01, 32'h3000_0034, 32'h0, 4'hF, 32'h0, 16'd0, 0);
        n_checks++;
        if ({o_st, o_dat, o_polls} !== {e_st, e_dat, e_polls} || stb_len !== 256) begin
            n_errors++; $display("FAIL ack_at_timeout: got %h/%h/%0d len=%0d want %h/%h/%0d len=256", o_st, o_dat, o_polls, stb_len, e_st, e_dat, e_polls);
        end
        // One cycle too late is a timeout.
        ack_lat = 256;
        model(2'b00, 32'h0, 32'h0, 16'd0, 1'b1);
        run_cmd(2'b00, 32'h3000_0038, 32'h55, 4'h1, 32'h0, 16'd0, 0);
        n_checks++;
        if ({o_st, o_dat, o_polls} !== {e_st, e_dat, e_polls} || n_wr !== 0) begin
            n_errors++; $display("FAIL ack_after_timeout: got %h/%h/%0d writes=%0d want %h/%h/%0d", o_st, o_dat, o_polls, n_wr, e_st, e_dat, e_polls);
        end
        ack_lat = 0;
        model(2'b11, 32'h0, 32'h0, 16'd0, 1'b0);
        run_cmd(2'b11, 32'h3000_0040, 32'hFFFF_FFFF, 4'hF, 32'h0, 16'd0, 0);
        n_checks++;
        if ({o_st, o_dat, o_polls} !== {e_st, e_dat, e_polls} || n_trans !== 0 || rsp_cyc !== acc_cyc) begin
            n_errors++; $display("FAIL illegal_op: got %h/%h/%0d trans=%0d want %h/%h/%0d trans=0", o_st, o_dat, o_polls, n_trans, e_st, e_dat, e_polls);
        end
    endtask

    task automatic test_backpressure();
        ack_lat = 3;
        rd_q.delete(); rd_q.push_back(32'hBEEF_0010);
        run_cmd(2'b01, 32'h3000_0050, 32'h0, 4'hF, 32'h0, 16'd0, 10);
        n_checks++;
        if (!o_stable || o_cr_resp !== 1'b0 || o_busy_resp !== 1'b1 || o_dat !== 32'hBEEF_0010) begin
            n_errors++; $display("FAIL backpressure: stable=%0d cmd_ready=%b busy=%b dat=%h want 1/0/1/beef0010", o_stable, o_cr_resp, o_busy_resp, o_dat);
        end
        n_checks++;
        if (o_after !== 3'b010) begin
            n_errors++; $display("FAIL backpressure_release: {rsp_valid,cmd_ready,busy}=%b want 010", o_after);
        end
    endtask

    task automatic test_reset_mid_bus();
        bit seen;
        never_ack = 1;
        @(posedge wb_clk_i); #1;
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_adr = 32'h3000_0060;
        @(posedge wb_clk_i); #1;
        cmd_valid = 1'b0;
        repeat (5) begin @(posedge wb_clk_i); #1; end
        n_checks++;
        if (wbm_cyc_o !== 1'b1) begin
            n_errors++; $display("FAIL rst_mid_setup: cyc=%b want 1", wbm_cyc_o);
        end
        wb_rst_i = 1'b1;
        @(posedge wb_clk_i); #1;
        wb_rst_i = 1'b0;
        n_checks++;
        if ({wbm_cyc_o, wbm_stb_o, rsp_valid, busy, cmd_ready} !== 5'b00001) begin
            n_errors++; $display("FAIL rst_mid_bus: {cyc,stb,rsp_valid,busy,cmd_ready}=%b want 00001", {wbm_cyc_o, wbm_stb_o, rsp_valid, busy, cmd_ready});
        end
        seen = 0;
        repeat (300) begin
            @(posedge wb_clk_i); #1;
            if (rsp_valid || wbm_cyc_o) seen = 1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_errors++; $display("FAIL rst_no_response: activity=%0d want 0", seen);
        end
        never_ack = 0;
    endtask

    task automatic test_back_to_back();
        logic [1:0]  op;
        logic [31:0] exp;
        logic [15:0] maxp;
        stray = 1;
        for (int it = 0; it < 25; it++) begin
            op = 2'($urandom_range(0, 3));
            ack_lat = $urandom_range(0, 4);
            never_ack = ($urandom_range(0, 9) == 0);
            exp = 32'($urandom_range(0, 3));
            maxp = 16'($urandom_range(0, 5));
            rd_q.delete();
            for (int k = 0; k < 6; k++) rd_q.push_back($urandom);
            model(op, exp, 32'h3, maxp, never_ack);
            run_cmd(op, $urandom, exp, 4'($urandom), 32'h3, maxp, $urandom_range(0, 3));
            n_checks++;
            if ({o_st, o_dat, o_polls} !== {e_st, e_dat, e_polls} || n_trans !== e_ntr || o_hung) begin
                n_errors++; $display("FAIL b2b_%0d op=%0d: got %h/%h/%0d trans=%0d want %h/%h/%0d trans=%0d", it, op, o_st, o_dat, o_polls, n_trans, e_st, e_dat, e_polls, e_ntr);
            end
            if (n_trans > 0) begin
                n_checks++;
                if (gaps[0] < 1) begin
                    n_errors++; $display("FAIL b2b_idle_%0d: got %0d idle cycles want >=1", it, gaps[0]);
                end
            end
            n_checks++;
            if (o_after !== 3'b010) begin
                n_errors++; $display("FAIL b2b_after_%0d: {rsp_valid,cmd_ready,busy}=%b want 010", it, o_after);
            end
        end
        stray = 0;
        never_ack = 0;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_poll_match();
        test_poll_exhaust();
        test_timeout_illegal();
        test_backpressure();
        test_reset_mid_bus();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
